// File: rtl/fpga_row_cfg_loader.sv
// ---------------------------------------------------------------------------
// fpga_row_cfg_loader
//
// Purpose: byte-serial configuration loader for one FPGA row. Bytes arrive
// over a valid/ready handshake and are assembled LSB-first in a shadow
// register. When the last byte is in, the whole configuration is committed to
// the row's three configuration buses on a single edge. The row therefore
// never sees a half-loaded configuration, and it keeps running on the old
// configuration while a reload is in progress.
//
// Optional feature, selected by the macro FPGA_CFG_CRC_EN:
//   defined   - one CRC-8 trailer byte follows the data bytes. The CRC uses
//               poly 0x07, init 0x00, MSB-first, with no reflection and no
//               final XOR. A mismatch rejects the load.
//   undefined - there is no CRC logic and cfg_error is tied to 0.
//
// Ports:
//   clk        in   1         clock, rising edge
//   rst        in   1         synchronous active-high reset
//   start      in   1         begins a load; sampled only in IDLE
//   din        in   8         bitstream byte
//   din_valid  in   1         din holds a byte
//   din_ready  out  1         loader accepts a byte this cycle
//   busy       out  1         state is not IDLE
//   cfg_done   out  1         last load committed (level)
//   cfg_error  out  1         last load rejected by CRC (level)
//   brbselect  out  BRB_BITS  active routing-block configuration
//   bsbselect  out  BSB_BITS  active switch-block configuration
//   lbselect   out  LB_BITS   active logic-block configuration
// ---------------------------------------------------------------------------
module fpga_row_cfg_loader #(
  parameter int wire_width = 3,
  parameter int fpga_width = 5
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    start,
  input  logic [7:0]                                              din,
  input  logic                                                    din_valid,
  output logic                                                    din_ready,
  output logic                                                    busy,
  output logic                                                    cfg_done,
  output logic                                                    cfg_error,
  output logic [fpga_width*wire_width*12-1:0]                     brbselect,
  output logic [(fpga_width-1)*wire_width*wire_width*12-1:0]      bsbselect,
  output logic [(fpga_width-1)*5-1:0]                             lbselect
);

  localparam int BRB_BITS = fpga_width * wire_width * 12;
  localparam int BSB_BITS = (fpga_width - 1) * wire_width * wire_width * 12;
  localparam int LB_BITS  = (fpga_width - 1) * 5;
  localparam int CFG_BITS = BRB_BITS + BSB_BITS + LB_BITS;
  localparam int NBYTES   = (CFG_BITS + 7) / 8;
  localparam int CW       = $clog2(NBYTES + 1);

`ifdef FPGA_CFG_CRC_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
`endif

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic                  done_reg, done_next;
  logic                  byte_we;
  logic                  commit;
  logic [CFG_BITS-1:0]   shadow_reg, shadow_next;
  logic [BRB_BITS-1:0]   brb_reg;
  logic [BSB_BITS-1:0]   bsb_reg;
  logic [LB_BITS-1:0]    lb_reg;

`ifdef FPGA_CFG_CRC_EN
  logic [7:0]            crc_reg, crc_next;
  logic                  error_reg, error_next;

  // Folds one byte into the CRC. The CRC is shifted MSB-first with poly x^8+x^2+x+1.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  // Next-state and control logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = done_reg;
    byte_we    = 1'b0;
    commit     = 1'b0;
`ifdef FPGA_CFG_CRC_EN
    crc_next   = crc_reg;
    error_next = error_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          cnt_next   = '0;
          done_next  = 1'b0;
`ifdef FPGA_CFG_CRC_EN
          crc_next   = 8'h00;
          error_next = 1'b0;
`endif
          state_next = LOAD;
        end
      end
      LOAD: begin
        // din_ready is always high here, so a valid byte is always accepted.
        if (din_valid) begin
          byte_we  = 1'b1;
          cnt_next = cnt_reg + 1'b1;
`ifdef FPGA_CFG_CRC_EN
          crc_next = crc8_update(crc_reg, din);
`endif
          if (cnt_reg == CW'(NBYTES - 1)) begin
`ifdef FPGA_CFG_CRC_EN
            state_next = CHECK;
`else
            state_next = COMMIT;
`endif
          end
        end
      end
`ifdef FPGA_CFG_CRC_EN
      CHECK: begin
        if (din_valid) begin
          if (din == crc_reg) begin
            state_next = COMMIT;
          end else begin
            error_next = 1'b1;
            state_next = IDLE;
          end
        end
      end
`endif
      COMMIT: begin
        commit     = 1'b1;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow byte lanes. A lane is written only while the counter selects it.
  // Bits of the last byte that lie beyond CFG_BITS have no lane and are dropped.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    localparam int LO = gi * 8;
    localparam int HI = (LO + 7 < CFG_BITS) ? LO + 7 : CFG_BITS - 1;
    assign shadow_next[HI:LO] = (byte_we && cnt_reg == CW'(gi)) ? din[HI-LO:0]
                                                                : shadow_reg[HI:LO];
  end

  // The shadow register does not need reset. It is never visible until a
  // complete load has overwritten every lane.
  always_ff @(posedge clk) begin
    shadow_reg <= shadow_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      brb_reg   <= '0;
      bsb_reg   <= '0;
      lb_reg    <= '0;
`ifdef FPGA_CFG_CRC_EN
      crc_reg   <= 8'h00;
      error_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
`ifdef FPGA_CFG_CRC_EN
      crc_reg   <= crc_next;
      error_reg <= error_next;
`endif
      if (commit) begin
        brb_reg <= shadow_reg[BRB_BITS-1:0];
        bsb_reg <= shadow_reg[BRB_BITS +: BSB_BITS];
        lb_reg  <= shadow_reg[CFG_BITS-1 -: LB_BITS];
      end
    end
  end

  // These outputs decode registered state only, so no input reaches an output combinationally.
`ifdef FPGA_CFG_CRC_EN
  assign din_ready = (state_reg == LOAD) || (state_reg == CHECK);
  assign cfg_error = error_reg;
`else
  assign din_ready = (state_reg == LOAD);
  assign cfg_error = 1'b0;
`endif
  assign busy      = (state_reg != IDLE);
  assign cfg_done  = done_reg;
  assign brbselect = brb_reg;
  assign bsbselect = bsb_reg;
  assign lbselect  = lb_reg;

endmodule

// File: doc/fpga_row_cfg_loader.md
# fpga_row_cfg_loader

Configuration loader that sits directly upstream of the FPGA row and drives its three configuration buses (`brbselect`, `bsbselect`, `lbselect`). It accepts a byte-serial bitstream over a valid/ready handshake and assembles it in a shadow register. On completion it commits the whole configuration to the row in a single cycle, so the row never sees a partially loaded configuration. An optional CRC-8 trailer guards the commit.

## Interface

**Parameters**
- `wire_width`, default 3: wires per channel; must match the row.
- `fpga_width`, default 5: tiles per row; must match the row.
- Derived (localparam):
  - `BRB_BITS = fpga_width*wire_width*12` (default 180).
  - `BSB_BITS = (fpga_width-1)*wire_width*wire_width*12` (default 432).
  - `LB_BITS = (fpga_width-1)*5` (default 20).
  - `CFG_BITS = BRB_BITS+BSB_BITS+LB_BITS` (default 632).
  - `NBYTES = ceil(CFG_BITS/8)` (default 79).

**Ports**
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begins a load; sampled only in IDLE.
- `din`  in  8  bitstream byte.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  loader accepts a byte this cycle.
- `busy`  out  1  load in progress (any state other than IDLE).
- `cfg_done`  out  1  last load committed successfully; level.
- `cfg_error`  out  1  last load rejected; level.
- `brbselect`  out  BRB_BITS  active routing-block configuration.
- `bsbselect`  out  BSB_BITS  active switch-block configuration.
- `lbselect`  out  LB_BITS  active logic-block configuration.

## Operation

**States:** IDLE, LOAD, CHECK (CRC builds only), COMMIT.

**IDLE**
- `din_ready` is 0.
- `start` = 1 has the following effect:
  - byte counter ← 0;
  - CRC ← 0x00;
  - `cfg_done` ← 0 and `cfg_error` ← 0;
  - next state is LOAD.

**LOAD**
- `din_ready` is 1.
- Each cycle with `din_valid && din_ready`:
  - byte k is written to shadow bits [8k+7:8k], LSB-first;
  - the counter is incremented.
- Bits at index ≥ CFG_BITS in the last byte are discarded. They are still fed to the CRC.
- When byte NBYTES-1 is accepted, the next state is CHECK if CRC is enabled, otherwise COMMIT.

**CHECK**
- `din_ready` is 1.
- One trailer byte is accepted and compared against the running CRC.
- Match: next state is COMMIT.
- Mismatch: `cfg_error` ← 1 and next state is IDLE. The active outputs are unchanged.

**COMMIT** (one cycle)
- All three outputs load from the shadow register on the same edge:
  - shadow [BRB_BITS-1:0] → `brbselect`;
  - next BSB_BITS → `bsbselect`;
  - top LB_BITS → `lbselect`.
- `cfg_done` ← 1.
- Next state is IDLE.

**Held configuration:** active outputs hold the previous configuration throughout LOAD and CHECK, so the row keeps operating during a reload.

**Boundary conditions**
- `start` outside IDLE is ignored. No restart, no abort.
- `din_valid` while `din_ready` = 0 is ignored; the byte is dropped and no state changes.
- The loader never stalls on its own: `din_ready` stays high for the whole of LOAD and CHECK.
- `rst` mid-load has the following effect:
  - state ← IDLE;
  - counter ← 0;
  - all outputs ← 0, including the active configuration, which is cleared to the unconfigured row.
- Counter width is `$clog2(NBYTES+1)`. No wrap-around can occur, because LOAD exits at NBYTES-1.

## Timing

- **Reset values** (on the edge where `rst` is 1): `din_ready` = 0, `busy` = 0, `cfg_done` = 0, `cfg_error` = 0, and `brbselect`/`bsbselect`/`lbselect` all 0.
- **Start:** `start` sampled at edge E0 puts the loader in LOAD, with `din_ready` = 1 from after E0.
- **Throughput:** one byte per cycle at full rate.
- **Commit latency, no CRC:** the final byte is accepted at edge Ef. New outputs and `cfg_done` = 1 are visible after edge Ef+1. `busy` falls after Ef+1.
- **Commit latency, with CRC:** the trailer is accepted at edge Et. Outputs and `cfg_done` update after Et+1. On mismatch, `cfg_error` = 1 is visible after Et, and the loader is in IDLE after Et.
- **Minimum full load** (defaults, no CRC): 1 + 79 + 1 = 81 cycles from `start` to `cfg_done`.
- **Output glitching:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- Macro: `FPGA_CFG_CRC_EN`.
- **Defined:**
  - CHECK state is present and one trailer byte follows the NBYTES data bytes.
  - CRC-8 parameters: polynomial 0x07, init 0x00, MSB-first per byte, no reflection, no final XOR.
  - The CRC covers all NBYTES data bytes, including padding bits.
- **Undefined:**
  - No CHECK state and no CRC logic.
  - COMMIT follows the final data byte directly.
  - `cfg_error` is tied to 0.

## Test plan

1. **Reset:** assert `rst` for 2 cycles with random inputs → all outputs 0, `din_ready` = 0.
2. **Full load, CRC off, defaults, counting pattern:** 79 bytes with byte k = k[7:0], one per cycle, `din_valid` held high → `brbselect[7:0]` = 0x00 and `brbselect[15:8]` = 0x01. `lbselect` equals shadow bits [631:612] of the pattern. `cfg_done` = 1 exactly one edge after the 79th acceptance, with exactly 81 cycles from `start`.
3. **Throttled source plus ignored inputs:** `din_valid` toggles every other cycle, and `start` is pulsed mid-load → same result as scenario 2. The `start` pulse has no effect. Outputs hold the old configuration until COMMIT.
4. **CRC pass:** CRC on; 79 zero bytes plus trailer 0x00 → commit, `cfg_done` = 1, all outputs 0.
5. **CRC fail:**
   - CRC on; first complete a load of all 0xFF data bytes.
   - Then send 79 zero bytes plus trailer 0x01.
   - → `cfg_error` = 1, `cfg_done` = 0, and the outputs remain at the earlier all-ones configuration.
6. **Reset mid-load:** assert `rst` after 40 bytes → state IDLE and all outputs 0. A subsequent full load completes normally.
